// File: rtl/nes_bus_bridge_if.sv
// Bus bundle for nes_bus_bridge: 6502-side access port, slave channel bus and IRQ lines.
// The bridge takes the master modport (it masters the slave channels); CPU/slave models take slave.
interface nes_bus_bridge_if #(
  parameter int unsigned DT_SZ = 8,
  parameter int unsigned AD_SZ = 16,
  parameter int unsigned N_CH  = 4
);
  logic                    cpu_req;
  logic [AD_SZ-1:0]        cpu_addr;
  logic                    cpu_r_bw;
  logic [DT_SZ-1:0]        cpu_wdata;
  logic [DT_SZ-1:0]        cpu_rdata;
  logic                    cpu_rdy;
  logic                    cpu_done;
  logic                    bus_err;
  logic                    err_clr;
  logic [N_CH-1:0]         s_cs;
  logic [AD_SZ-1:0]        s_addr;
  logic                    s_r_bw;
  logic [DT_SZ-1:0]        s_wdata;
  logic [N_CH*DT_SZ-1:0]   s_rdata;
  logic [N_CH-1:0]         s_ack;
  logic [N_CH-1:0]         irq_src;
  logic [N_CH-1:0]         irq_clr;
  logic                    b_irq;

  modport master (
    input  cpu_req, cpu_addr, cpu_r_bw, cpu_wdata, err_clr, s_rdata, s_ack, irq_src, irq_clr,
    output cpu_rdata, cpu_rdy, cpu_done, bus_err, s_cs, s_addr, s_r_bw, s_wdata, b_irq
  );

  modport slave (
    output cpu_req, cpu_addr, cpu_r_bw, cpu_wdata, err_clr, s_rdata, s_ack, irq_src, irq_clr,
    input  cpu_rdata, cpu_rdy, cpu_done, bus_err, s_cs, s_addr, s_r_bw, s_wdata, b_irq
  );
endinterface

// File: rtl/nes_bus_bridge.sv
// NES CPU-to-peripheral bus bridge: one-hot channel select, wait/timeout FSM, open-bus latch.
// Define NES_BUS_IRQ_EN to build the per-channel edge-triggered IRQ pending logic.
module nes_bus_bridge #(
  parameter int unsigned DT_SZ   = 8,
  parameter int unsigned AD_SZ   = 16,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic             NES_clk,
  input logic             NES_rst,
  nes_bus_bridge_if.master bus
);

  localparam int unsigned SelW = $clog2(N_CH);
  localparam int unsigned CntW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e           state_q, state_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AD_SZ-1:0] addr_q, addr_d;
  logic             r_bw_q, r_bw_d;
  logic [DT_SZ-1:0] wdata_q, wdata_d;
  logic [DT_SZ-1:0] rdata_q, rdata_d;
  logic [N_CH-1:0]  cs_q, cs_d;
  logic             err_q, err_d;
  logic [SelW-1:0]  req_sel;
  logic [DT_SZ-1:0] rd_sel;
  logic             ack_sel;

  assign req_sel = bus.cpu_addr[AD_SZ-1 -: SelW];
  assign ack_sel = bus.s_ack[sel_q];

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_q == SelW'(i)) rd_sel = bus.s_rdata[i*DT_SZ +: DT_SZ];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    r_bw_d  = r_bw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    err_d   = err_q & ~bus.err_clr;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          addr_d        = bus.cpu_addr;
          r_bw_d        = bus.cpu_r_bw;
          wdata_d       = bus.cpu_wdata;
          sel_d         = req_sel;
          cnt_d         = '0;
          cs_d          = '0;
          cs_d[req_sel] = 1'b1;
          state_d       = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        // Ack is checked first so an ack on the final allowed cycle is never an error.
        if (ack_sel) begin
          rdata_d = r_bw_q ? rd_sel : wdata_q;
          cs_d    = '0;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cs_d    = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge NES_clk or posedge NES_rst) begin
    if (NES_rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      r_bw_q  <= 1'b1;
      wdata_q <= '0;
      rdata_q <= '0;
      cs_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      r_bw_q  <= r_bw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_rdy   = (state_q != StAccess);
  assign bus.cpu_done  = (state_q == StDone);
  assign bus.bus_err   = err_q;
  assign bus.s_cs      = cs_q;
  assign bus.s_addr    = addr_q;
  assign bus.s_r_bw    = r_bw_q;
  assign bus.s_wdata   = wdata_q;

`ifdef NES_BUS_IRQ_EN
  logic [N_CH-1:0] irq_src_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic            b_irq_q;

  // A rising edge sets after the clear is applied, so set wins on collision.
  assign pend_d = (pend_q & ~bus.irq_clr) | (bus.irq_src & ~irq_src_q);

  always_ff @(posedge NES_clk or posedge NES_rst) begin
    if (NES_rst) begin
      irq_src_q <= '0;
      pend_q    <= '0;
      b_irq_q   <= 1'b1;
    end else begin
      irq_src_q <= bus.irq_src;
      pend_q    <= pend_d;
      b_irq_q   <= ~|pend_q;
    end
  end

  assign bus.b_irq = b_irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{bus.irq_src, bus.irq_clr};
  assign bus.b_irq  = 1'b1;
`endif

endmodule

// File: tb/tb_nes_bus_bridge.sv
// Self-checking bench for nes_bus_bridge: directed spec scenarios plus randomized accesses
// compared against a transaction-level model (expected latency, open-bus value, sticky error).
module tb_nes_bus_bridge;
  localparam int unsigned DT_SZ   = 8;
  localparam int unsigned AD_SZ   = 16;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned TIMEOUT = 15;

  logic NES_clk = 1'b0;
  logic NES_rst;
  always #5 NES_clk = ~NES_clk;

  nes_bus_bridge_if #(.DT_SZ(DT_SZ), .AD_SZ(AD_SZ), .N_CH(N_CH)) bus ();

  nes_bus_bridge #(.DT_SZ(DT_SZ), .AD_SZ(AD_SZ), .N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .NES_clk (NES_clk),
    .NES_rst (NES_rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_rdata;
  logic       exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdata"}, bus.cpu_rdata, 0);
    check({tag, "_s_addr"}, bus.s_addr, 0);
    check({tag, "_s_r_bw"}, bus.s_r_bw, 1);
    check({tag, "_s_wdata"}, bus.s_wdata, 0);
    check({tag, "_bus_err"}, bus.bus_err, 0);
    check({tag, "_s_cs"}, bus.s_cs, 0);
    check({tag, "_rdy"}, bus.cpu_rdy, 1);
    check({tag, "_done"}, bus.cpu_done, 0);
    check({tag, "_b_irq"}, bus.b_irq, 1);
  endtask

  // ack_at: ACCESS cycle index (0-based) where the selected slave acks; out of range = no ack.
  // clr_at: ACCESS cycle index where err_clr is pulsed; negative = never.
  task automatic run_access(input logic [15:0] addr, input logic r_bw, input logic [7:0] wdata,
                            input int ack_at, input logic [7:0] rdval, input bit stray,
                            input bit busy, input int clr_at);
    int sel;
    int exp_cyc;
    bit tmo;
    int n_acc;
    int done_k;
    logic [3:0] onehot;
    sel     = int'(addr[15:14]);
    tmo     = !(ack_at >= 0 && ack_at < int'(TIMEOUT));
    exp_cyc = tmo ? int'(TIMEOUT) : ack_at + 1;
    onehot  = 4'b0001 << sel;
    n_acc   = 0;
    done_k  = -1;

    @(negedge NES_clk);
    check("rdy_before_req", bus.cpu_rdy, 1);
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_r_bw  = r_bw;
    bus.cpu_wdata = wdata;
    for (int k = 1; k <= 40; k++) begin
      @(negedge NES_clk);
      bus.cpu_req = 1'b0;
      bus.s_ack   = '0;
      bus.err_clr = 1'b0;
      bus.s_rdata = $urandom;
      if (bus.cpu_done === 1'b1) begin
        done_k = k;
        break;
      end
      if (bus.cpu_rdy === 1'b0) begin
        check("s_cs_access", bus.s_cs, onehot);
        if (busy && n_acc == 1) begin
          bus.cpu_req   = 1'b1;
          bus.cpu_addr  = ~addr;
          bus.cpu_r_bw  = ~r_bw;
          bus.cpu_wdata = ~wdata;
        end
        if (n_acc == ack_at) begin
          bus.s_ack[sel]            = 1'b1;
          bus.s_rdata[sel*8 +: 8]   = rdval;
        end
        if (stray) bus.s_ack[(sel + 1) % N_CH] = 1'b1;
        if (n_acc == clr_at) bus.err_clr = 1'b1;
        n_acc++;
      end
    end

    if (!tmo) exp_rdata = r_bw ? rdval : wdata;
    if (tmo) exp_err = 1'b1;
    else if (clr_at >= 0 && clr_at < exp_cyc) exp_err = 1'b0;

    check("done_latency", done_k, exp_cyc + 1);
    check("access_cycles", n_acc, exp_cyc);
    check("cpu_rdata", bus.cpu_rdata, exp_rdata);
    check("bus_err", bus.bus_err, exp_err);
    check("s_addr", bus.s_addr, addr);
    check("s_r_bw", bus.s_r_bw, r_bw);
    check("s_wdata", bus.s_wdata, wdata);
    check("s_cs_done", bus.s_cs, 0);
    bus.s_ack   = '0;
    bus.cpu_req = 1'b0;
    bus.err_clr = 1'b0;
    @(negedge NES_clk);
    check("done_single", bus.cpu_done, 0);
    check("rdy_after", bus.cpu_rdy, 1);
  endtask

  initial begin
    NES_rst       = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_r_bw  = 1'b0;
    bus.cpu_wdata = '0;
    bus.err_clr   = 1'b0;
    bus.s_rdata   = '0;
    bus.s_ack     = '0;
    bus.irq_src   = '0;
    bus.irq_clr   = '0;
    exp_rdata     = '0;
    exp_err       = 1'b0;
    repeat (2) @(negedge NES_clk);
    check_reset_values("reset");
    NES_rst = 1'b0;
    @(negedge NES_clk);
    check_reset_values("post_reset");

    // Zero-wait read on channel 1.
    run_access(16'h4016, 1'b1, 8'h00, 0, 8'hA5, 1'b0, 1'b0, -1);
    // Write to channel 3 acked on the 4th ACCESS cycle.
    run_access(16'hC000, 1'b0, 8'h3C, 3, 8'h00, 1'b0, 1'b0, -1);
    // Timeout: no ack, open bus holds 3C, error sets then clears.
    run_access(16'h0123, 1'b1, 8'h11, -1, 8'h77, 1'b0, 1'b0, -1);
    @(negedge NES_clk);
    bus.err_clr = 1'b1;
    @(negedge NES_clk);
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_clr", bus.bus_err, exp_err);
    // Ack on the final allowed cycle beats the timeout.
    run_access(16'h8042, 1'b1, 8'h00, int'(TIMEOUT) - 1, 8'h5A, 1'b0, 1'b0, -1);
    // Busy request and stray ack on another channel are ignored.
    run_access(16'h4000, 1'b1, 8'h00, 2, 8'hC3, 1'b1, 1'b1, -1);
    // Timeout with a simultaneous err_clr: timeout wins.
    run_access(16'h8001, 1'b0, 8'h99, -1, 8'h00, 1'b0, 1'b0, int'(TIMEOUT) - 1);
    // err_clr during a normal access clears the sticky flag.
    run_access(16'h0002, 1'b0, 8'h42, 4, 8'h00, 1'b0, 1'b0, 1);

    for (int n = 0; n < 24; n++) begin
      int ack_at;
      int clr_at;
      ack_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 2));
      clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT)) : -1;
      run_access(16'($urandom), 1'($urandom), 8'($urandom), ack_at, 8'($urandom),
                 1'($urandom), 1'($urandom), clr_at);
    end

    // Reset mid-access: outputs drop without a clock edge, no done pulse.
    @(negedge NES_clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h8000;
    bus.cpu_r_bw = 1'b1;
    @(negedge NES_clk);
    bus.cpu_req = 1'b0;
    @(negedge NES_clk);
    check("rst_pre_rdy", bus.cpu_rdy, 0);
    check("rst_pre_cs", bus.s_cs, 4'b0100);
    #1 NES_rst = 1'b1;
    #1;
    check("rst_async_cs", bus.s_cs, 0);
    check("rst_async_rdy", bus.cpu_rdy, 1);
    check("rst_async_done", bus.cpu_done, 0);
    @(negedge NES_clk);
    check("rst_hold_done", bus.cpu_done, 0);
    NES_rst = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    check_reset_values("mid_reset");
    @(negedge NES_clk);
    check("rst_after_done", bus.cpu_done, 0);
    check("rst_after_rdy", bus.cpu_rdy, 1);

`ifdef NES_BUS_IRQ_EN
    check("irq_idle", bus.b_irq, 1);
    bus.irq_src[2] = 1'b1;
    repeat (3) @(negedge NES_clk);
    check("irq_set", bus.b_irq, 0);
    bus.irq_clr[2] = 1'b1;
    @(negedge NES_clk);
    bus.irq_clr = '0;
    repeat (3) @(negedge NES_clk);
    check("irq_clr", bus.b_irq, 1);
    bus.irq_src = '0;
`else
    bus.irq_src = '1;
    repeat (3) @(negedge NES_clk);
    check("irq_off_src", bus.b_irq, 1);
    bus.irq_clr = '1;
    bus.irq_src = '0;
    repeat (3) @(negedge NES_clk);
    check("irq_off_clr", bus.b_irq, 1);
    bus.irq_clr = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
